// File: rtl/ins_loader.sv
// ins_loader: framed byte-stream program loader writing big-endian 32-bit words into instruction memory.
// Define INS_LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte (adds the CHECK and ERR states).
module ins_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter logic [7:0] BASE_ADDR = 8'h00
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        im_we,
    output logic [7:0]  im_addr,
    output logic [31:0] im_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err,
    output logic [8:0]  words_loaded
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_COUNT = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd5;
`ifdef INS_LOADER_CHECKSUM_EN
    localparam logic [2:0] ST_CHECK = 3'd4;
    localparam logic [2:0] ST_ERR   = 3'd6;
    localparam logic [2:0] ST_AFTER_LAST = ST_CHECK;
`else
    localparam logic [2:0] ST_AFTER_LAST = ST_DONE;
`endif

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [8:0]  r_count;
    logic [1:0]  r_byte_cnt;
    logic [7:0]  r_addr;
    logic [31:0] r_wdata;
    logic [8:0]  r_words;
    logic        r_we;
    logic        r_done;
    logic        r_hold;
    logic        r_ready;
    logic        w_accept;
    logic        w_is_sync;
    logic        w_last;
    logic        w_start;

    assign w_accept  = rx_valid & r_ready;
    assign w_is_sync = (rx_data == SYNC_BYTE);
    assign w_last    = ((r_words + 9'd1) == r_count);
    assign w_start   = (w_state_nxt == ST_COUNT) && (r_state != ST_COUNT);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_sync) w_state_nxt = ST_COUNT;
            end
            ST_COUNT: begin
                if (w_accept) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (w_accept && (r_byte_cnt == 2'd3)) w_state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                w_state_nxt = w_last ? ST_AFTER_LAST : ST_DATA;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
`ifdef INS_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (w_accept) w_state_nxt = (rx_data == r_csum) ? ST_DONE : ST_ERR;
            end
            ST_ERR: begin
                if (w_accept && w_is_sync) w_state_nxt = ST_COUNT;
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Control outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            r_hold  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_we    <= (w_state_nxt == ST_WRITE);
            r_done  <= (w_state_nxt == ST_DONE);
            r_hold  <= (w_state_nxt != ST_IDLE);
            r_ready <= !((w_state_nxt == ST_WRITE) || (w_state_nxt == ST_DONE));
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_count    <= '0;
            r_byte_cnt <= '0;
            r_addr     <= BASE_ADDR;
            r_wdata    <= '0;
            r_words    <= '0;
        end else begin
            if (w_start) begin
                r_words    <= '0;
                r_addr     <= BASE_ADDR;
                r_byte_cnt <= '0;
            end
            // A count byte of zero stands for a full 256-word frame.
            if ((r_state == ST_COUNT) && w_accept) begin
                r_count <= {(rx_data == 8'h00), rx_data};
            end
            if ((r_state == ST_DATA) && w_accept) begin
                r_wdata    <= {r_wdata[23:0], rx_data};
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
            if (r_state == ST_WRITE) begin
                r_addr  <= r_addr + 8'd1;
                r_words <= r_words + 9'd1;
            end
        end
    end

`ifdef INS_LOADER_CHECKSUM_EN
    logic [7:0] r_csum;
    logic       r_err;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_csum <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= (w_state_nxt == ST_ERR);
            if (w_start) begin
                r_csum <= '0;
            end else if ((r_state == ST_DATA) && w_accept) begin
                r_csum <= r_csum ^ rx_data;
            end
        end
    end

    assign load_err = r_err;
`else
    assign load_err = 1'b0;
`endif

    assign rx_ready     = r_ready;
    assign im_we        = r_we;
    assign im_addr      = r_addr;
    assign im_wdata     = r_wdata;
    assign cpu_hold     = r_hold;
    assign load_done    = r_done;
    assign words_loaded = r_words;

endmodule
